// File: rtl/me_fetch_ctrl_if.sv
// Handshake and status bundle between the ME fetch controller and the cur buffer / ref SRAM side.
// The controller takes the master modport; widths must match the controller's parameters.
interface me_fetch_ctrl_if #(
  parameter int SLOT_W = 1,
  parameter int BEAT_W = 6,
  parameter int BLK_W  = 2
);
  logic              start;
  logic              cur_valid;
  logic              ref_valid;
  logic              need_cur;
  logic              need_ref;
  logic              cur_wr_en;
  logic [SLOT_W-1:0] cur_wr_slot;
  logic [BEAT_W-1:0] cur_wr_beat;
  logic [SLOT_W-1:0] cur_rd_slot;
  logic              cur_next_block;
  logic              ref_next_line;
  logic [BLK_W-1:0]  block_idx;
  logic              busy;
  logic              done;

  modport master (
    input  start, cur_valid, ref_valid,
    output need_cur, need_ref, cur_wr_en, cur_wr_slot, cur_wr_beat, cur_rd_slot,
           cur_next_block, ref_next_line, block_idx, busy, done
  );

  modport slave (
    output start, cur_valid, ref_valid,
    input  need_cur, need_ref, cur_wr_en, cur_wr_slot, cur_wr_beat, cur_rd_slot,
           cur_next_block, ref_next_line, block_idx, busy, done
  );
endinterface

// File: rtl/me_fetch_ctrl.sv
// Fetch/schedule controller for the ME datapath: prefetches cur blocks into a slot ring
// and streams the ref search window line by line for each block.
module me_fetch_ctrl #(
  parameter int BLK_SIZE   = 16,
  parameter int SR         = 8,
  parameter int CUR_PIX    = 4,
  parameter int REF_PIX    = 8,
  parameter int PREFETCH   = 2,
  parameter int NUM_BLOCKS = 4
) (
  input  logic           clk,
  input  logic           rst,
  me_fetch_ctrl_if.master bus
);
  localparam int WIN       = BLK_SIZE + 2 * SR;
  localparam int CUR_BEATS = BLK_SIZE * BLK_SIZE / CUR_PIX;
  localparam int REF_BEATS = WIN / REF_PIX;
  localparam int BOOT_N    = (PREFETCH < NUM_BLOCKS) ? PREFETCH : NUM_BLOCKS;
  localparam int SLOT_W    = (PREFETCH > 1) ? $clog2(PREFETCH) : 1;
  localparam int BEAT_W    = (CUR_BEATS > 1) ? $clog2(CUR_BEATS) : 1;
  localparam int RBEAT_W   = (REF_BEATS > 1) ? $clog2(REF_BEATS) : 1;
  localparam int LINE_W    = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int FILL_W    = $clog2(PREFETCH + 1);
  localparam int ISS_W     = $clog2(NUM_BLOCKS + 1);

  localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(PREFETCH);
  localparam logic [FILL_W-1:0]  BOOT_FILL  = FILL_W'(BOOT_N);
  localparam logic [ISS_W-1:0]   ISS_MAX    = ISS_W'(NUM_BLOCKS);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(PREFETCH - 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(CUR_BEATS - 1);
  localparam logic [RBEAT_W-1:0] RBEAT_LAST = RBEAT_W'(REF_BEATS - 1);
  localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(WIN - 1);
  localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {IDLE, BOOT, SEARCH, WAIT_CUR, DONE} state_t;

  state_t              state_reg, state_next;
  logic [FILL_W-1:0]   filled_reg, filled_next;
  logic [ISS_W-1:0]    issued_reg;
  logic [BEAT_W-1:0]   wr_beat_reg;
  logic [SLOT_W-1:0]   wr_slot_reg;
  logic [SLOT_W-1:0]   rd_slot_reg;
  logic [RBEAT_W-1:0]  ref_beat_reg;
  logic [LINE_W-1:0]   ref_line_reg;
  logic [BLK_W-1:0]    block_idx_reg;
  logic                blk_end_reg;
  logic                line_end_reg;

  logic busy, start_go, need_cur, need_ref, cur_acc, ref_acc;
  logic slot_done, line_done, blk_last, blk_is_last;

  function automatic logic [SLOT_W-1:0] slot_adv(input logic [SLOT_W-1:0] s);
    return (s == SLOT_LAST) ? '0 : s + 1'b1;
  endfunction

  assign busy        = (state_reg == BOOT) || (state_reg == SEARCH) || (state_reg == WAIT_CUR);
  assign start_go    = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign need_cur    = busy && (filled_reg < FILL_MAX) && (issued_reg < ISS_MAX);
  // The block-end cycle is a deliberate bubble: the next block's ref lines start after it.
  assign need_ref    = (state_reg == SEARCH) && !blk_end_reg;
  assign cur_acc     = need_cur && bus.cur_valid;
  assign ref_acc     = need_ref && bus.ref_valid;
  assign slot_done   = cur_acc && (wr_beat_reg == BEAT_LAST);
  assign line_done   = ref_acc && (ref_beat_reg == RBEAT_LAST);
  assign blk_last    = line_done && (ref_line_reg == LINE_LAST);
  assign blk_is_last = (block_idx_reg == BLK_LAST);

  // A slot completing on the block-end cycle cancels the release of the searched slot.
  always_comb begin
    filled_next = filled_reg;
    if (slot_done && !blk_end_reg) begin
      filled_next = filled_reg + 1'b1;
    end else if (!slot_done && blk_end_reg) begin
      filled_next = filled_reg - 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE: if (bus.start) state_next = BOOT;
      BOOT:       if (filled_reg == BOOT_FILL) state_next = SEARCH;
      SEARCH: begin
        if (blk_end_reg) begin
          if (blk_is_last)              state_next = DONE;
          else if (filled_next != '0)   state_next = SEARCH;
          else                          state_next = WAIT_CUR;
        end
      end
      WAIT_CUR:   if (filled_reg != '0) state_next = SEARCH;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      filled_reg    <= '0;
      issued_reg    <= '0;
      wr_beat_reg   <= '0;
      wr_slot_reg   <= '0;
      rd_slot_reg   <= '0;
      ref_beat_reg  <= '0;
      ref_line_reg  <= '0;
      block_idx_reg <= '0;
      blk_end_reg   <= 1'b0;
      line_end_reg  <= 1'b0;
    end else begin
      filled_reg   <= filled_next;
      blk_end_reg  <= blk_last;
      line_end_reg <= line_done;
      if (cur_acc) begin
        if (slot_done) begin
          wr_beat_reg <= '0;
          wr_slot_reg <= slot_adv(wr_slot_reg);
          issued_reg  <= issued_reg + 1'b1;
        end else begin
          wr_beat_reg <= wr_beat_reg + 1'b1;
        end
      end
      if (ref_acc) begin
        if (line_done) begin
          ref_beat_reg <= '0;
          ref_line_reg <= blk_last ? '0 : ref_line_reg + 1'b1;
        end else begin
          ref_beat_reg <= ref_beat_reg + 1'b1;
        end
      end
      if (blk_end_reg) begin
        rd_slot_reg <= slot_adv(rd_slot_reg);
        if (!blk_is_last) block_idx_reg <= block_idx_reg + 1'b1;
      end
    end
  end

  assign bus.need_cur       = need_cur;
  assign bus.need_ref       = need_ref;
  assign bus.cur_wr_en      = cur_acc;
  assign bus.cur_wr_slot    = wr_slot_reg;
  assign bus.cur_wr_beat    = wr_beat_reg;
  assign bus.cur_rd_slot    = rd_slot_reg;
  assign bus.cur_next_block = blk_end_reg;
  assign bus.ref_next_line  = line_end_reg;
  assign bus.block_idx      = block_idx_reg;
  assign bus.busy           = busy;
  assign bus.done           = (state_reg == DONE);
endmodule

// File: tb/tb_me_fetch_ctrl.sv
// Bench for me_fetch_ctrl: per-cycle comparison against a beat-count reference model,
// scenario table with end-of-segment totals, plus reset/NUM_BLOCKS=1 sequences.
module tb_me_fetch_ctrl;
  localparam int NB = 4, PF = 2, CB = 64, RB = 4, WIN = 32, BLK_BEATS = WIN * RB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  me_fetch_ctrl_if #(.SLOT_W(1), .BEAT_W(6), .BLK_W(2)) bus ();
  me_fetch_ctrl_if #(.SLOT_W(1), .BEAT_W(6), .BLK_W(1)) bus1 ();

  me_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  me_fetch_ctrl #(.NUM_BLOCKS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef enum {M_IDLE, M_BOOT, M_SRCH, M_WAIT, M_DONE} ph_t;
  ph_t ph;
  int  cb, rb, bdone;
  bit  pend_blk, pend_line;

  int checks = 0, errors = 0;
  int cnt_cnb, cnt_rnl, cnt_curb, cnt_refb;

  typedef struct {
    int st; int cvm; int rvm; int ncyc; bit chk;
    int blk; int dn; int cnb; int rnl; int curb; int refb;
  } seg_t;
  seg_t segs[5];

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic void model_clear();
    cb = 0; rb = 0; bdone = 0; pend_blk = 0; pend_line = 0;
  endfunction

  function automatic logic [16:0] exp_vec(input bit cv);
    int issued, filled, bi;
    bit bz, nc, nr;
    issued = cb / CB;
    filled = issued - bdone;
    bz = (ph == M_BOOT) || (ph == M_SRCH) || (ph == M_WAIT);
    nc = bz && (filled < PF) && (issued < NB);
    nr = (ph == M_SRCH) && !pend_blk;
    bi = (bdone < NB - 1) ? bdone : NB - 1;
    return {nc, nr, nc && cv, 1'(issued % PF), 6'(cb % CB), 1'(bdone % PF),
            pend_blk, pend_line, 2'(bi), bz, (ph == M_DONE)};
  endfunction

  function automatic void model_step(input bit s, input bit cv, input bit rv);
    int issued, filled;
    bit nc, nr, nl, nbk;
    if (rst) begin model_clear(); ph = M_IDLE; return; end
    if ((ph == M_IDLE || ph == M_DONE) && s) begin model_clear(); ph = M_BOOT; return; end
    issued = cb / CB;
    filled = issued - bdone;
    nc  = ((ph == M_BOOT) || (ph == M_SRCH) || (ph == M_WAIT)) && (filled < PF) && (issued < NB) && cv;
    nr  = (ph == M_SRCH) && !pend_blk && rv;
    nl  = nr && (rb % RB == RB - 1);
    nbk = nr && ((rb + 1) % BLK_BEATS == 0);
    case (ph)
      M_BOOT: if (filled == ((PF < NB) ? PF : NB)) ph = M_SRCH;
      M_SRCH: if (pend_blk) begin
                if (bdone == NB - 1) ph = M_DONE;
                else if ((cb + int'(nc)) / CB - (bdone + 1) > 0) ph = M_SRCH;
                else ph = M_WAIT;
              end
      M_WAIT: if (filled > 0) ph = M_SRCH;
      default: ;
    endcase
    cb += int'(nc);
    rb += int'(nr);
    if (pend_blk) bdone++;
    pend_line = nl;
    pend_blk  = nbk;
  endfunction

  function automatic logic [16:0] act_vec();
    return {bus.need_cur, bus.need_ref, bus.cur_wr_en, bus.cur_wr_slot, bus.cur_wr_beat,
            bus.cur_rd_slot, bus.cur_next_block, bus.ref_next_line, bus.block_idx,
            bus.busy, bus.done};
  endfunction

  task automatic cyc(input bit s, input bit cv, input bit rv);
    logic [16:0] e, a;
    bus.start = s; bus.cur_valid = cv; bus.ref_valid = rv;
    #1;
    e = exp_vec(cv);
    a = act_vec();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got %h want %h", $time, a, e);
    end
    cnt_cnb  += int'(bus.cur_next_block);
    cnt_rnl  += int'(bus.ref_next_line);
    cnt_curb += int'(bus.cur_wr_en);
    cnt_refb += int'(bus.need_ref && bus.ref_valid);
    model_step(s, cv, rv);
    @(negedge clk);
  endtask

  function automatic bit mode_bit(input int m, input int i);
    case (m)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      default: return (i % 2 == 0);
    endcase
  endfunction

  initial begin
    int n, c1, n1, first_ref, nc_after;
    bit got_done;
    // st: 0 none, 1 first cycle, 2 random; valid modes: 0 low, 1 high, 2 random, 3 toggle
    segs[0] = '{1, 1, 1,  700, 1, 3, 1, 4, 128, 256, 512};
    segs[1] = '{1, 1, 1,  130, 1, 0, 0, 0,   0, 128,   0};
    segs[2] = '{0, 0, 1,  400, 1, 2, 0, 2,  64,   0, 256};
    segs[3] = '{0, 1, 3,  700, 1, 3, 1, 2,  64, 128, 256};
    segs[4] = '{2, 2, 2, 3000, 0, 0, 0, 0,   0,   0,   0};

    bus.start = 0; bus.cur_valid = 0; bus.ref_valid = 0;
    bus1.start = 0; bus1.cur_valid = 0; bus1.ref_valid = 0;
    model_clear(); ph = M_IDLE;
    @(negedge clk);
    repeat (3) cyc(0, 1, 1);
    rst = 1'b0;
    #1;
    chk("reset_state", int'(act_vec()), 0);
    chk("reset_state_nb1", int'(bus1.busy || bus1.done || bus1.need_cur), 0);
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      cnt_cnb = 0; cnt_rnl = 0; cnt_curb = 0; cnt_refb = 0;
      for (int i = 0; i < segs[k].ncyc; i++) begin
        cyc((segs[k].st == 1 && i == 0) || (segs[k].st == 2 && $urandom_range(0, 7) == 0),
            mode_bit(segs[k].cvm, i), mode_bit(segs[k].rvm, i));
      end
      if (segs[k].chk) begin
        chk($sformatf("seg%0d_block_idx", k), int'(bus.block_idx), segs[k].blk);
        chk($sformatf("seg%0d_done", k), int'(bus.done), segs[k].dn);
        chk($sformatf("seg%0d_cur_next_block", k), cnt_cnb, segs[k].cnb);
        chk($sformatf("seg%0d_ref_next_line", k), cnt_rnl, segs[k].rnl);
        chk($sformatf("seg%0d_cur_beats", k), cnt_curb, segs[k].curb);
        chk($sformatf("seg%0d_ref_beats", k), cnt_refb, segs[k].refb);
      end
    end

    // Reset mid-search at block 2, then rerun from block 0.
    rst = 1'b1; cyc(0, 1, 1); rst = 1'b0;
    cyc(1, 1, 1);
    n = 0;
    while (!(bdone == 2 && ph == M_SRCH && !pend_blk) && n < 2000) begin
      cyc(0, 1, 1); n++;
    end
    chk("reach_block2", int'(n < 2000), 1);
    repeat (20) cyc(0, 1, 1);
    chk("pre_rst_block_idx", int'(bus.block_idx), 2);
    rst = 1'b1; cyc(0, 1, 1); rst = 1'b0;
    #1;
    chk("rst_mid_search", int'(act_vec()), 0);
    @(negedge clk);
    cyc(1, 1, 1);
    repeat (60) cyc(0, 1, 1);
    chk("rerun_block_idx", int'(bus.block_idx), 0);
    chk("rerun_busy", int'(bus.busy), 1);

    // NUM_BLOCKS=1 instance: one 64-beat boot, one block, then done.
    bus.start = 0; bus.cur_valid = 0; bus.ref_valid = 0;
    bus1.start = 1;
    @(negedge clk);
    bus1.start = 0; bus1.cur_valid = 1; bus1.ref_valid = 1;
    c1 = 0; n1 = 0; first_ref = -1; got_done = 0; n = 0;
    while (!got_done && n < 600) begin
      #1;
      if (bus1.need_ref && first_ref < 0) first_ref = c1;
      c1 += int'(bus1.cur_wr_en);
      n1 += int'(bus1.cur_next_block);
      got_done = bus1.done;
      n++;
      @(negedge clk);
    end
    chk("nb1_done_reached", int'(got_done), 1);
    chk("nb1_boot_beats", first_ref, 64);
    chk("nb1_cur_beats", c1, 64);
    chk("nb1_cur_next_block", n1, 1);
    nc_after = 0;
    repeat (10) begin
      #1; nc_after += int'(bus1.need_cur || bus1.need_ref);
      @(negedge clk);
    end
    chk("nb1_idle_after_done", nc_after, 0);
    chk("nb1_done_holds", int'(bus1.done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/me_fetch_ctrl.md
Name: me_fetch_ctrl

Overview:
- Parametrised fetch/schedule controller for the motion-estimation datapath; successor to the fixed cur-read counter and cold-boot logic in the ME top.
- Issues and accepts current-block beats into a PREFETCH-slot cur buffer, and streams the reference search window line by line per block.
- Generates the cur_next_block and ref_next_line strobes consumed by the cur buffer and ref SRAM.
- Processes NUM_BLOCKS blocks per start, with configurable block size, search range, beat widths and prefetch depth.

Parameters:
- BLK_SIZE, 16, block edge in pixels
- SR, 8, search range in pixels; window edge WIN = BLK_SIZE+2*SR (32)
- CUR_PIX, 4, cur pixels per beat; CUR_BEATS = BLK_SIZE*BLK_SIZE/CUR_PIX (64)
- REF_PIX, 8, ref pixels per beat; REF_BEATS = WIN/REF_PIX (4)
- PREFETCH, 2, cur buffer slots (>=1); cold boot fills min(PREFETCH,NUM_BLOCKS)
- NUM_BLOCKS, 4, blocks per run (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- cur_valid  in  1  cur_in beat present
- ref_valid  in  1  ref_in beat present
- need_cur  out  1  request cur beat; beat accepted when need_cur&&cur_valid
- need_ref  out  1  request ref beat; beat accepted when need_ref&&ref_valid
- cur_wr_en  out  1  = need_cur&&cur_valid (combinational)
- cur_wr_slot  out  max(1,clog2(PREFETCH))  slot being filled
- cur_wr_beat  out  clog2(CUR_BEATS)  beat index within slot
- cur_rd_slot  out  max(1,clog2(PREFETCH))  slot under search
- cur_next_block  out  1  1-cycle pulse when a block's search completes
- ref_next_line  out  1  1-cycle pulse the cycle after a ref line's last beat
- block_idx  out  max(1,clog2(NUM_BLOCKS))  block under search
- busy  out  1  state not IDLE/DONE
- done  out  1  high in DONE

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE, all counters 0, every output 0. Reset mid-run aborts immediately; no pending pulses survive.
- States: IDLE, BOOT, SEARCH, WAIT_CUR, DONE.
- IDLE/DONE --start--> BOOT; all counters cleared on that edge. start is ignored while busy.
- Counters: filled (0..PREFETCH), issued (blocks fully written, 0..NUM_BLOCKS), wr_beat, wr_slot, rd_slot, ref_beat, ref_line, block_idx.
- need_cur = busy && filled<PREFETCH && issued<NUM_BLOCKS. Outputs depend only on registered state, except cur_wr_en.
- Cur accept: wr_beat increments.
  - At wr_beat==CUR_BEATS-1: wr_beat->0, wr_slot advances mod PREFETCH, issued++, filled++.
- BOOT -> SEARCH when filled==min(PREFETCH,NUM_BLOCKS); this is the cold boot.
- need_ref = (state==SEARCH). Ref accept: ref_beat increments.
  - At ref_beat==REF_BEATS-1: ref_beat->0, ref_line++, ref_next_line pulses on the next cycle.
- Block end: ref accept with ref_line==WIN-1 and ref_beat==REF_BEATS-1. Next cycle:
  - cur_next_block=1.
  - ref_line->0, filled--, rd_slot advances mod PREFETCH.
  - If block_idx==NUM_BLOCKS-1: state->DONE and block_idx holds.
  - Otherwise block_idx++, and state->SEARCH if post-update filled>0, else WAIT_CUR.
- Ref beats are fetched during the search; they are not prefetched. need_ref is 0 on the block-end cycle, so there is one bubble between blocks.
- Simultaneous cur slot completion and block end in the same update: filled is unchanged (net +1-1).
- WAIT_CUR -> SEARCH when filled>0. Cur fetch continues during SEARCH and WAIT_CUR.
- ref_next_line and cur_next_block coincide on a block's final line.
- Valid deasserted mid-line or mid-block: counters hold, no strobes.
- Widths: counters sized to their max value; no overflow is possible by construction.

Test Plan:
- Defaults, cur_valid=ref_valid=1, start pulse -> BOOT lasts 128 accept cycles (slots 0,1). SEARCH entered; 32 ref_next_line pulses and 1 cur_next_block per block. done after 4 blocks; cur_next_block count=4, total cur beats=256, ref beats=512.
- cur_valid held 0 after boot -> blocks 0,1 complete; state enters WAIT_CUR with filled=0 and need_ref=0. Restoring cur_valid -> SEARCH 1 cycle after slot completion.
- NUM_BLOCKS=1, PREFETCH=2 -> BOOT ends at filled=1 (64 beats). Exactly one cur_next_block, then done=1; need_cur=0 afterwards.
- ref_valid toggled every other cycle -> ref_next_line spacing=8 cycles. Line count per block still 32; block_idx 0->1->2->3.
- rst asserted for 1 cycle mid-SEARCH (block_idx=2) -> next cycle all outputs 0, state IDLE. start then reruns from block_idx=0.
- start pulsed during SEARCH -> ignored, counts unchanged. start in DONE -> new run with issued=0 and wr_slot=0.
